// File: rtl/pong_pkg.sv
// Screen/paddle geometry shared by the ball engine, draw stage and paddle controller,
// plus the ball engine state encoding.
package pong_pkg;

  localparam int H_SCREEN  = 640;
  localparam int V_SCREEN  = 480;
  localparam int BORDER    = 10;
  localparam int BALL_SIZE = 10;
  localparam int P_OFFSET  = 20;
  localparam int P_WIDTH   = 8;
  localparam int P_HIGH    = 96;
  localparam int SPEED_X   = 2;
  localparam int SPEED_Y   = 2;

  localparam int L_FACE  = BORDER + P_OFFSET + P_WIDTH;
  localparam int R_FACE  = H_SCREEN - L_FACE;
  localparam int SERVE_Y = (V_SCREEN - BALL_SIZE) / 2;

  typedef enum logic [1:0] {
    PARK = 2'd0,
    PLAY = 2'd1,
    GOAL = 2'd2
  } ball_state_e;

  // side 0 serves from the left paddle face, side 1 from the right one
  function automatic logic [9:0] serve_x(input logic side);
    return side ? 10'(R_FACE - BALL_SIZE) : 10'(L_FACE);
  endfunction

  function automatic logic [10:0] ext11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/pong_paddle_overlap.sv
// Vertical overlap test between the ball and one paddle, done on widened operands
// so neither sum can wrap.
module pong_paddle_overlap
  import pong_pkg::*;
(
  input  logic [9:0] ball_y_i,
  input  logic [9:0] paddle_y_i,
  output logic       overlap_o
);

  logic [10:0] ball_top;
  logic [10:0] ball_bot;
  logic [10:0] pad_top;
  logic [10:0] pad_bot;

  assign ball_top  = ext11(ball_y_i);
  assign ball_bot  = ext11(ball_y_i) + 11'(BALL_SIZE);
  assign pad_top   = ext11(paddle_y_i);
  assign pad_bot   = ext11(paddle_y_i) + 11'(P_HIGH);
  assign overlap_o = (ball_bot > pad_top) && (ball_top < pad_bot);

endmodule

// File: rtl/pong_ball_engine.sv
// Per-frame ball motion: serve, wall/paddle bounce and goal detection, all stepped
// once per frame_tick while in PLAY.
module pong_ball_engine
  import pong_pkg::*;
(
  input  logic       clk_pix,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       park,
  input  logic       serve,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       in_play,
  output logic       goal_left,
  output logic       goal_right
);

  localparam logic [10:0] BS     = 11'(BALL_SIZE);
  localparam logic [10:0] SX     = 11'(SPEED_X);
  localparam logic [10:0] SY     = 11'(SPEED_Y);
  localparam logic [10:0] LF     = 11'(L_FACE);
  localparam logic [10:0] RF     = 11'(R_FACE);
  localparam logic [10:0] X_RLIM = 11'(H_SCREEN - BORDER);
  localparam logic [10:0] Y_BLIM = 11'(V_SCREEN - BORDER);
  localparam logic [10:0] X_LLIM = 11'(BORDER + SPEED_X);
  localparam logic [10:0] Y_TLIM = 11'(BORDER + SPEED_Y);

  ball_state_e state_q, state_d;
  logic        side_q, side_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        dx_q, dx_d;
  logic        dy_q, dy_d;

  logic        ov_p1, ov_p2;
  logic [10:0] x_w, y_w;
  logic        hit_l, hit_r, goal_l_ev, goal_r_ev;

  pong_paddle_overlap u_ov_p1 (
    .ball_y_i  (y_q),
    .paddle_y_i(p1_y),
    .overlap_o (ov_p1)
  );

  pong_paddle_overlap u_ov_p2 (
    .ball_y_i  (y_q),
    .paddle_y_i(p2_y),
    .overlap_o (ov_p2)
  );

  assign x_w = ext11(x_q);
  assign y_w = ext11(y_q);

  // dx=1 means moving left, dy=1 means moving up
  assign hit_l     = dx_q && (x_w >= LF) && (x_w < LF + SX) && ov_p1;
  assign hit_r     = !dx_q && (x_w + BS <= RF) && (x_w + BS + SX > RF) && ov_p2;
  assign goal_l_ev = dx_q && (x_w < X_LLIM) && !hit_l;
  assign goal_r_ev = !dx_q && (x_w + BS + SX > X_RLIM) && !hit_r;

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state_q <= PARK;
      side_q  <= 1'b0;
      x_q     <= 10'(L_FACE);
      y_q     <= 10'(SERVE_Y);
      dx_q    <= 1'b0;
      dy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PARK: if (!park && serve) state_d = PLAY;
      PLAY: begin
        if (park)
          state_d = PARK;
        else if (frame_tick && (goal_l_ev || goal_r_ev))
          state_d = GOAL;
      end
      GOAL:    state_d = PARK;
      default: state_d = PARK;
    endcase
  end

  always_comb begin
    in_play    = (state_q == PLAY);
    goal_left  = (state_q == GOAL) && !side_q;
    goal_right = (state_q == GOAL) && side_q;
  end

  // Any path into PARK lands on the serve spot, so the parked ball never shows a stale position.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    side_d = side_q;
    if (state_d == PARK) begin
      x_d  = serve_x(side_q);
      y_d  = 10'(SERVE_Y);
      dx_d = side_q;
      dy_d = 1'b0;
    end else if (state_q == PLAY && frame_tick) begin
      if (hit_l) begin
        x_d  = 10'(L_FACE);
        dx_d = 1'b0;
      end else if (hit_r) begin
        x_d  = 10'(R_FACE - BALL_SIZE);
        dx_d = 1'b1;
      end else if (goal_l_ev) begin
        x_d    = 10'(BORDER);
        side_d = 1'b0;
      end else if (goal_r_ev) begin
        x_d    = 10'(H_SCREEN - BORDER - BALL_SIZE);
        side_d = 1'b1;
      end else if (dx_q) begin
        x_d = x_q - 10'(SPEED_X);
      end else begin
        x_d = x_q + 10'(SPEED_X);
      end

      if (!dy_q && (y_w + BS + SY > Y_BLIM)) begin
        y_d  = 10'(V_SCREEN - BORDER - BALL_SIZE);
        dy_d = 1'b1;
      end else if (dy_q && (y_w < Y_TLIM)) begin
        y_d  = 10'(BORDER);
        dy_d = 1'b0;
      end else if (dy_q) begin
        y_d = y_q - 10'(SPEED_Y);
      end else begin
        y_d = y_q + 10'(SPEED_Y);
      end
    end
  end

  assign ball_x = x_q;
  assign ball_y = y_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: serve, wall bounce, paddle hits, goals, park and reset.
module tb_pong_ball_engine;

  logic       clk_pix = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       park;
  logic       serve;
  logic [9:0] p1_y;
  logic [9:0] p2_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       in_play;
  logic       goal_left;
  logic       goal_right;

  int n_assert = 0;
  int n_fail   = 0;

  pong_ball_engine dut (
    .clk_pix   (clk_pix),
    .reset     (reset),
    .frame_tick(frame_tick),
    .park      (park),
    .serve     (serve),
    .p1_y      (p1_y),
    .p2_y      (p2_y),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .in_play   (in_play),
    .goal_left (goal_left),
    .goal_right(goal_right)
  );

  always #20 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk_pix);
    #1;
  endtask

  // one frame tick followed by one idle cycle
  task automatic tick();
    frame_tick = 1'b1;
    clk_step();
    frame_tick = 1'b0;
    clk_step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic serve_pulse();
    serve = 1'b1;
    clk_step();
    serve = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; park = 1'b0; serve = 1'b0;
    p1_y = 10'd200; p2_y = 10'd120;
    clk_step();
    clk_step();
    check("rst_x", 16'(ball_x), 16'd38);
    check("rst_y", 16'(ball_y), 16'd235);
    check("rst_in_play", 16'(in_play), 16'd0);
    check("rst_goal_l", 16'(goal_left), 16'd0);
    check("rst_goal_r", 16'(goal_right), 16'd0);
    reset = 1'b0;
    clk_step();

    // reset in the middle of play
    serve_pulse();
    check("serve_in_play", 16'(in_play), 16'd1);
    ticks(5);
    check("t5_x", 16'(ball_x), 16'd48);
    check("t5_y", 16'(ball_y), 16'd245);
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    check("midrst_x", 16'(ball_x), 16'd38);
    check("midrst_y", 16'(ball_y), 16'd235);
    check("midrst_in_play", 16'(in_play), 16'd0);
    check("midrst_goal_l", 16'(goal_left), 16'd0);
    check("midrst_goal_r", 16'(goal_right), 16'd0);

    // left serve: bottom wall bounce then right paddle hit (p2_y=120)
    serve_pulse();
    tick();
    check("t1_x", 16'(ball_x), 16'd40);
    check("t1_y", 16'(ball_y), 16'd237);
    ticks(111);
    check("t112_y", 16'(ball_y), 16'd459);
    tick();
    check("t113_y", 16'(ball_y), 16'd460);
    tick();
    check("t114_y", 16'(ball_y), 16'd458);
    check("t114_x", 16'(ball_x), 16'd266);
    ticks(162);
    check("t276_x", 16'(ball_x), 16'd590);
    tick();
    check("t277_x", 16'(ball_x), 16'd592);
    check("t277_y", 16'(ball_y), 16'd132);
    tick();
    check("t278_x", 16'(ball_x), 16'd592);
    check("t278_y", 16'(ball_y), 16'd130);
    tick();
    check("t279_x", 16'(ball_x), 16'd590);
    check("t279_y", 16'(ball_y), 16'd128);
    clk_step();
    check("idle_x", 16'(ball_x), 16'd590);

    // serve coincident with frame_tick, then right-paddle miss
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    p2_y = 10'd300;
    serve = 1'b1; frame_tick = 1'b1;
    clk_step();
    serve = 1'b0; frame_tick = 1'b0;
    check("stick_in_play", 16'(in_play), 16'd1);
    check("stick_x", 16'(ball_x), 16'd38);
    check("stick_y", 16'(ball_y), 16'd235);
    clk_step();
    check("stick_hold_x", 16'(ball_x), 16'd38);
    tick();
    check("miss_t1_x", 16'(ball_x), 16'd40);
    check("miss_t1_y", 16'(ball_y), 16'd237);
    ticks(289);
    check("miss_t290_x", 16'(ball_x), 16'd618);
    tick();
    check("miss_t291_x", 16'(ball_x), 16'd620);
    frame_tick = 1'b1;
    clk_step();
    frame_tick = 1'b0;
    check("goal_r_pulse", 16'(goal_right), 16'd1);
    check("goal_r_other", 16'(goal_left), 16'd0);
    check("goal_r_in_play", 16'(in_play), 16'd0);
    check("goal_r_x", 16'(ball_x), 16'd620);
    clk_step();
    check("goal_r_end", 16'(goal_right), 16'd0);
    check("park_r_in_play", 16'(in_play), 16'd0);
    check("park_r_x", 16'(ball_x), 16'd592);
    check("park_r_y", 16'(ball_y), 16'd235);
    serve_pulse();
    tick();
    check("rserve_x", 16'(ball_x), 16'd590);
    check("rserve_y", 16'(ball_y), 16'd237);
    check("rserve_in_play", 16'(in_play), 16'd1);

    // park wins over serve and frame_tick
    park = 1'b1; serve = 1'b1; frame_tick = 1'b1;
    clk_step();
    frame_tick = 1'b0;
    check("park_in_play", 16'(in_play), 16'd0);
    check("park_goal_l", 16'(goal_left), 16'd0);
    check("park_goal_r", 16'(goal_right), 16'd0);
    clk_step();
    check("park_hold_in_play", 16'(in_play), 16'd0);
    check("park_hold_x", 16'(ball_x), 16'd592);
    check("park_hold_y", 16'(ball_y), 16'd235);
    serve = 1'b0;
    park  = 1'b0;
    clk_step();
    check("unpark_in_play", 16'(in_play), 16'd0);

    // right serve: left paddle hit (p1_y=120)
    p1_y = 10'd120;
    serve_pulse();
    ticks(277);
    check("lhit_t277_x", 16'(ball_x), 16'd38);
    check("lhit_t277_y", 16'(ball_y), 16'd132);
    tick();
    check("lhit_t278_x", 16'(ball_x), 16'd38);
    tick();
    check("lhit_t279_x", 16'(ball_x), 16'd40);

    // right serve again, left paddle miss -> left goal
    park = 1'b1;
    clk_step();
    park = 1'b0;
    p1_y = 10'd300;
    clk_step();
    serve_pulse();
    ticks(291);
    check("lgoal_t291_x", 16'(ball_x), 16'd10);
    frame_tick = 1'b1;
    clk_step();
    frame_tick = 1'b0;
    check("goal_l_pulse", 16'(goal_left), 16'd1);
    check("goal_l_other", 16'(goal_right), 16'd0);
    check("goal_l_x", 16'(ball_x), 16'd10);
    clk_step();
    check("goal_l_end", 16'(goal_left), 16'd0);
    check("park_l_x", 16'(ball_x), 16'd38);
    check("park_l_y", 16'(ball_y), 16'd235);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
- Per-frame ball motion engine for the pong game.
- Holds ball position and direction, serves the ball, bounces it off walls and paddles, and flags goals.
- Sits upstream of the frame renderer/draw stage, which consumes ball_x/ball_y, and upstream of the score counters, which consume the goal pulses.
- Collision is analytic, computed from paddle positions, not from rendered pixels.

Parameters:
- H_SCREEN, 640, active width in pixels
- V_SCREEN, 480, active height in pixels
- BORDER, 10, wall thickness
- BALL_SIZE, 10, ball edge length
- P_OFFSET, 20, gap between wall and paddle
- P_WIDTH, 8, paddle width
- P_HIGH, 96, paddle height
- SPEED_X, 2, horizontal pixels per frame
- SPEED_Y, 2, vertical pixels per frame

Ports:
- clk_pix  in  1  pixel clock (25 MHz)
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame (y==480, x==0)
- park  in  1  level; forces ball parked (game not in play)
- serve  in  1  one-cycle launch pulse
- p1_y  in  10  left paddle top row
- p2_y  in  10  right paddle top row
- ball_x  out  10  ball left column
- ball_y  out  10  ball top row
- in_play  out  1  high in PLAY
- goal_left  out  1  one-cycle pulse: ball reached left wall (P2 scores)
- goal_right  out  1  one-cycle pulse: ball reached right wall (P1 scores)

Behaviour:
- Clock and reset: all state is registered on clk_pix. Reset has priority over every input.
- Reset values: state PARK, side=0 (left), ball_x=38, ball_y=235, dx=0 (right), dy=0 (down), in_play=0, goal pulses 0.
- Derived constants:
  - L_FACE = BORDER+P_OFFSET+P_WIDTH = 38
  - R_FACE = H_SCREEN-L_FACE = 602
  - serve position is x = L_FACE (left) or R_FACE-BALL_SIZE = 592 (right), y = (V_SCREEN-BALL_SIZE)/2 = 235.
- State PARK:
  - Every cycle, ball is forced to the serve position of `side`, and dx = side (away from server), dy = 0.
  - serve=1 and park=0: go to PLAY next cycle. A frame_tick in the same cycle causes no motion.
- State PLAY: on each frame_tick, x and y update independently; no change between ticks.
  - X, first match wins:
    - Paddle hit, left: dx=1, ball_x >= L_FACE, ball_x < L_FACE+SPEED_X, and vertical overlap with p1. Result: ball_x = L_FACE, dx = 0.
    - Paddle hit, right: dx=0, ball_x+BALL_SIZE <= R_FACE, ball_x+BALL_SIZE+SPEED_X > R_FACE, and overlap with p2. Result: ball_x = R_FACE-BALL_SIZE, dx = 1.
    - Left goal: dx=1 and ball_x < BORDER+SPEED_X. Result: ball_x = BORDER, goal_left = 1, side = 0, go to GOAL.
    - Right goal: dx=0 and ball_x+BALL_SIZE+SPEED_X > H_SCREEN-BORDER. Result: ball_x = H_SCREEN-BORDER-BALL_SIZE (620), goal_right = 1, side = 1, go to GOAL.
    - Otherwise: ball_x ± SPEED_X.
  - Overlap means ball_y+BALL_SIZE > pN_y and ball_y < pN_y+P_HIGH.
  - Y:
    - dy=0 and ball_y+BALL_SIZE+SPEED_Y > V_SCREEN-BORDER: ball_y = 460, dy = 1.
    - dy=1 and ball_y < BORDER+SPEED_Y: ball_y = BORDER, dy = 0.
    - Otherwise: ball_y ± SPEED_Y.
- State GOAL: lasts exactly one cycle, while the goal pulse is high, then goes to PARK. serve is ignored in GOAL. The conceding side serves next.
- park=1 in any state: go to PARK next cycle. No goal pulse is issued. park has priority over serve and frame_tick.
- Arithmetic:
  - All comparisons are additive, on 11-bit unsigned intermediates, so nothing underflows.
  - Outputs never leave the range [BORDER, H_SCREEN-BORDER-BALL_SIZE] × [BORDER, V_SCREEN-BORDER-BALL_SIZE].
- Latency: outputs change on the clk_pix edge that samples frame_tick (registered, 1 cycle).

Decomposition:
- pong_pkg holds:
  - screen and paddle geometry constants (shared with the draw stage and the paddle controller)
  - the state enum PARK/PLAY/GOAL
- One combinational sub-module: pong_paddle_overlap. Inputs ball_y and paddle_y; output is the overlap bit. It is instantiated twice.

Test Plan:
- Reset mid-PLAY (reset asserted after 5 ticks) -> next cycle ball at (38,235), in_play=0, no goal pulse.
- Left serve from reset, serve pulse, then 1 tick -> (40,237); after 112 ticks y=459; tick 113 -> y=460, dy flips; tick 114 -> y=458.
- Serve with frame_tick in same cycle -> in_play=1, position stays (38,235) until the following tick.
- Right-paddle hit: left serve, p2_y=120; tick 277 -> x=592, y=132; tick 278 -> x=592, dx=1; tick 279 -> x=590.
- Miss: same run with p2_y=300 -> tick 291 x=620; tick 292 goal_right one cycle, goal_left=0; next cycle PARK at (592,235); next serve moves ball left.
- park asserted during PLAY together with serve and frame_tick -> PARK next cycle, no motion, no goal pulse; serve is ignored while park=1.
